// File: rtl/keccak_round_sched_pkg.sv
// keccak_round_sched shared package
// state encoding, step bit indices and defaults
package keccak_pkg;

   localparam int NROUNDS_DEF = 24;
   localparam int NSTEPS      = 5;

   localparam int THETA = 0;
   localparam int RHO   = 1;
   localparam int PI    = 2;
   localparam int CHI   = 3;
   localparam int IOTA  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_THETA,
      S_RHO,
      S_PI,
      S_CHI,
      S_IOTA,
      S_FIN,
      S_ERR
   } state_t;

   // one-hot engine bit owned by a step state, zero otherwise
   function automatic logic [NSTEPS-1:0] step_bit(input state_t s);
      logic [NSTEPS-1:0] b;
      b = '0;
      case (s)
         S_THETA: b[THETA] = 1'b1;
         S_RHO:   b[RHO]   = 1'b1;
         S_PI:    b[PI]    = 1'b1;
         S_CHI:   b[CHI]   = 1'b1;
         S_IOTA:  b[IOTA]  = 1'b1;
         default: b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/keccak_round_sched_if.sv
// keccak_round_sched control bus
// master drives requests/completions, slave is the scheduler
interface keccak_round_sched_if;
   import keccak_pkg::*;

   logic              start;
   logic              abort;
   logic [NSTEPS-1:0] step_done;
   logic [NSTEPS-1:0] step_init;
   logic [4:0]        round;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, abort, step_done,
      input  step_init, round, busy, done, err
   );

   modport slave (
      input  start, abort, step_done,
      output step_init, round, busy, done, err
   );

endinterface

// File: rtl/keccak_round_sched_watchdog.sv
// step_watchdog: per-step cycle counter
// count is cycles already spent, so expired marks the STEP_TO-th cycle
module step_watchdog #(
   parameter int STEP_TO = 4095
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(STEP_TO + 1);

   logic [CW-1:0] count;

   assign expired = enable && (count == CW'(STEP_TO - 1));

   // restart on state entry, saturate once expired
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/keccak_round_sched.sv
// keccak_round_sched: sequences theta..iota per round
// with abort, watchdog timeout and sticky error
module keccak_round_sched
   import keccak_pkg::*;
#(
   parameter int NROUNDS = NROUNDS_DEF,
   parameter int STEP_TO = 4095
) (
   input logic                 clk,
   input logic                 rst,
   keccak_round_sched_if.slave bus
);

   localparam int RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
   localparam logic [RW-1:0] LAST = RW'(NROUNDS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [RW-1:0]     rnd;
   logic [NSTEPS-1:0] init_q;
   logic              err_q;
   logic              in_step;
   logic              step_ok;
   logic              accept;
   logic              expired;

   assign in_step = state inside {S_THETA, S_RHO, S_PI, S_CHI, S_IOTA};
   assign step_ok = in_step && ((bus.step_done & step_bit(state)) != '0);
   assign accept  = (state == S_IDLE) && bus.start && !bus.abort;

   step_watchdog #(
      .STEP_TO (STEP_TO)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_nxt != state),
      .enable  (in_step),
      .expired (expired)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // next state: abort first, then own step_done, then timeout
   always_comb begin
      state_nxt = state;
      if (state != S_IDLE && bus.abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (accept) state_nxt = S_THETA;
            S_THETA: if (step_ok) state_nxt = S_RHO;
            S_RHO:   if (step_ok) state_nxt = S_PI;
            S_PI:    if (step_ok) state_nxt = S_CHI;
            S_CHI:   if (step_ok) state_nxt = S_IOTA;
            S_IOTA:  if (step_ok) state_nxt = (rnd == LAST) ? S_FIN : S_THETA;
            S_FIN:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
         endcase
         if (in_step && !step_ok && expired)
            state_nxt = S_ERR;
      end
   end

   // round index, entry pulses and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rnd    <= '0;
         init_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept)
            rnd <= '0;
         else if (state == S_IOTA && step_ok && !bus.abort && rnd != LAST)
            rnd <= rnd + 1'b1;
         init_q <= (state_nxt != state) ? step_bit(state_nxt) : '0;
         if (accept)
            err_q <= 1'b0;
         else if (state_nxt == S_ERR)
            err_q <= 1'b1;
      end
   end

   // outputs
   always_comb begin
      bus.step_init = init_q;
      bus.round     = 5'(rnd);
      bus.busy      = in_step || (state == S_FIN);
      bus.done      = (state == S_FIN);
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_keccak_round_sched.sv
// tb_keccak_round_sched: randomized engine responder
// against a round/step sequence model
module tb_keccak_round_sched;

   localparam int NR = 24;
   localparam int TO = 16;

   logic clk;
   logic rst;
   keccak_round_sched_if bus();

   keccak_round_sched #(
      .NROUNDS (NR),
      .STEP_TO (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   bit         tie = 0;
   bit         resp_on = 0;
   bit         noise_on = 0;
   int         lat_mode = 2;
   logic [4:0] skip = '0;
   logic [4:0] resp_done = '0;
   logic [4:0] pend = '0;
   int         cnt = 0;
   int         lat_q[$];

   logic [9:0] init_q[$];
   int         n_done = 0;
   int         done_cyc = -1;
   int         err_cyc = -1;
   int         rho_cyc = -1;

   initial clk = 0;
   always #5 clk = ~clk;

   assign bus.step_done = tie ? bus.step_init : resp_done;

   always @(posedge clk) cyc++;

   // engine responder: answers each init after a chosen latency
   always @(negedge clk) begin
      logic [4:0] fire;
      fire = '0;
      if (!resp_on || !rst) begin
         pend = '0;
      end else begin
         if (bus.step_init != 0) begin
            pend = bus.step_init;
            cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            lat_q.push_back(cnt);
         end
         if (pend != 0 && (pend & skip) == 0) begin
            if (cnt == 0) fire = pend;
            else cnt--;
         end
      end
      resp_done = fire | (noise_on ? (5'($urandom) & ~pend) : 5'd0);
      if (fire != 0) pend = '0;
   end

   // monitor: record init pulses, done and error timing
   always @(negedge clk) begin
      if (bus.step_init != 0) init_q.push_back({bus.round, bus.step_init});
      if (bus.step_init[1] && rho_cyc < 0) rho_cyc = cyc;
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (bus.err && err_cyc < 0) err_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lat_sum();
      int t;
      t = 0;
      foreach (lat_q[i]) t += lat_q[i] + 1;
      return t;
   endfunction

   task automatic do_start(output int s);
      @(negedge clk);
      init_q.delete();
      lat_q.delete();
      n_done = 0;
      done_cyc = -1;
      err_cyc = -1;
      rho_cyc = -1;
      bus.start = 1;
      s = cyc + 1;
      @(negedge clk);
      bus.start = 0;
   endtask

   task automatic wait_done(input string tag, input int budget,
                            input bit poke);
      int n;
      bit seen;
      bit poked;
      n = 0;
      seen = 0;
      poked = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         bus.start = 0;
         if (bus.done) seen = 1;
         if (poke && !poked && bus.round == 3 && bus.busy) begin
            bus.start = 1;
            poked = 1;
         end
         n++;
      end
      chk({tag, "_done_seen"}, seen, 1);
      if (poke) chk({tag, "_poked"}, poked, 1);
      @(negedge clk);
      bus.start = 0;
      chk({tag, "_busy_after"}, bus.busy, 0);
      chk({tag, "_round_hold"}, bus.round, NR - 1);
   endtask

   task automatic wait_init(input string tag, input int r, input int b,
                            input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (bus.round == r && bus.step_init[b]) ok = 1;
      end
      chk({tag, "_reached"}, ok, 1);
   endtask

   task automatic check_seq(input string tag);
      int bad;
      logic [9:0] e;
      bad = 0;
      chk({tag, "_ninit"}, init_q.size(), NR * 5);
      for (int r = 0; r < NR; r++) begin
         for (int s = 0; s < 5; s++) begin
            e = {5'(r), 5'(1 << s)};
            if (r * 5 + s >= init_q.size() || init_q[r * 5 + s] !== e) bad++;
         end
      end
      chk({tag, "_order"}, bad, 0);
      chk({tag, "_ndone"}, n_done, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_init"}, bus.step_init, 0);
      chk({tag, "_round"}, bus.round, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_err"}, bus.err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int s;
      int k;
      bit ok;
      bus.start = 0;
      bus.abort = 0;
      rst = 1;
      #1 rst = 0;
      #2 chk_zero("rst_async");
      repeat (2) @(negedge clk);
      chk_zero("rst_held");
      rst = 1;
      #1 chk_zero("rst_release");

      // nominal: every engine answers 2 cycles after init
      resp_on = 1;
      lat_mode = 2;
      do_start(s);
      chk("A_busy", bus.busy, 1);
      chk("A_first_init", bus.step_init, 1);
      wait_done("A", 1000, 0);
      check_seq("A");
      chk("A_done_cyc", done_cyc, s + NR * 5 * 3);

      // step_done tied to step_init: one cycle per step
      resp_on = 0;
      tie = 1;
      do_start(s);
      wait_done("B", 300, 0);
      check_seq("B");
      chk("B_done_cyc", done_cyc, s + NR * 5);

      // random latency, stray bits, start while busy
      tie = 0;
      resp_on = 1;
      lat_mode = -1;
      noise_on = 1;
      for (int it = 0; it < 2; it++) begin
         do_start(s);
         wait_done("C", 1000, 1);
         check_seq("C");
         chk("C_done_cyc", done_cyc, s + lat_sum());
         chk("C_err", bus.err, 0);
      end

      // step_done on the timeout cycle wins
      noise_on = 0;
      lat_mode = TO - 1;
      do_start(s);
      wait_done("D", 2200, 0);
      check_seq("D");
      chk("D_done_cyc", done_cyc, s + NR * 5 * TO);
      chk("D_err", bus.err, 0);

      // rho never answers
      lat_mode = 1;
      skip = 5'b00010;
      do_start(s);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.err) ok = 1;
      end
      chk("E_err_seen", ok, 1);
      chk("E_busy", bus.busy, 0);
      @(negedge clk);
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      repeat (4) @(negedge clk);
      chk("E_err_cyc", err_cyc, rho_cyc + TO);
      chk("E_ndone", n_done, 0);
      chk("E_ninit", init_q.size(), 2);
      chk("E_err_stuck", bus.err, 1);
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0;
      chk("E_err_sticky", bus.err, 1);
      chk("E_idle", bus.busy, 0);
      resp_on = 0;
      skip = '0;
      tie = 1;
      do_start(s);
      chk("E_err_clr", bus.err, 0);
      chk("E_restart", bus.busy, 1);
      wait_done("E", 300, 0);

      // abort in round 7 chi with simultaneous step_done
      do_start(s);
      wait_init("F", 7, 3, 200);
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0;
      chk("F_busy", bus.busy, 0);
      chk("F_init", bus.step_init, 0);
      chk("F_round", bus.round, 7);
      repeat (10) @(negedge clk);
      chk("F_ninit", init_q.size(), 7 * 5 + 4);
      chk("F_ndone", n_done, 0);

      // start and abort together in idle
      init_q.delete();
      bus.start = 1;
      bus.abort = 1;
      @(negedge clk);
      bus.start = 0;
      bus.abort = 0;
      chk("G_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      chk("G_ninit", init_q.size(), 0);

      // async reset in round 12 pi
      tie = 0;
      resp_on = 1;
      lat_mode = 2;
      do_start(s);
      wait_init("H", 12, 2, 1000);
      k = n_done;
      #2 rst = 0;
      resp_on = 0;
      #1 chk_zero("H_rst");
      @(negedge clk);
      chk_zero("H_hold");
      rst = 1;
      chk("H_ndone", k, 0);
      tie = 1;
      do_start(s);
      chk("H_round0", bus.round, 0);
      chk("H_init0", bus.step_init, 1);
      wait_done("H", 300, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/keccak_round_sched.md
KECCAK_ROUND_SCHED -- requirements
Module: keccak_round_sched

Interface
REQ-001 SHALL have parameter NROUNDS, default 24, number of Keccak-f rounds per permutation.
REQ-002 SHALL have parameter STEP_TO, default 4095, maximum cycles to wait for any step engine before flagging error.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one full permutation; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the permutation in progress.
REQ-007 SHALL have port step_done  input  5  per-engine completion, bit0 theta (col parity), bit1 rho (rotate), bit2 pi (permutation), bit3 chi (revaluate), bit4 iota (add RC).
REQ-008 SHALL have port step_init  output  5  one-cycle start pulse per engine, same bit order as step_done.
REQ-009 SHALL have port round  output  5  current round index 0..NROUNDS-1, also the iota round-constant index.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done or error.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the final iota completes.
REQ-012 SHALL have port err  output  1  sticky watchdog-timeout flag, cleared by the next accepted start or by reset.

Function
REQ-013 SHALL implement states IDLE, THETA, RHO, PI, CHI, IOTA, FIN, ERR.
REQ-014 SHALL move IDLE->THETA on start=1 and set round=0; step_init[0] SHALL pulse in the first THETA cycle.
REQ-015 SHALL pulse the matching step_init bit for exactly one cycle on every entry to THETA, RHO, PI, CHI or IOTA.
REQ-016 SHALL advance THETA->RHO->PI->CHI->IOTA only when the current state's own step_done bit is 1; all other step_done bits SHALL be ignored.
REQ-017 SHALL, on IOTA with step_done[4]=1: if round<NROUNDS-1, increment round and go to THETA; else go to FIN.
REQ-018 SHALL assert done for exactly the one FIN cycle, then return to IDLE with round held at NROUNDS-1.
REQ-019 SHALL let a step_done arriving in the same cycle as step_init advance the state, giving a minimum of 1 cycle per step.
REQ-020 SHALL count cycles spent in each step state, restarting at 0 on every state entry; on reaching STEP_TO without the matching step_done, go to ERR and set err.
REQ-021 SHALL give step_done priority over the timeout when both occur in the same cycle.
REQ-022 SHALL leave ERR for IDLE only on abort=1 or reset; err SHALL stay 1 until the next accepted start.
REQ-023 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with no done pulse and no further step_init; abort SHALL win over a simultaneous step_done.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL, on start=1 and abort=1 together in IDLE, stay in IDLE.
REQ-026 SHALL size the round counter to hold NROUNDS-1 without wrap; round SHALL never exceed NROUNDS-1.

Reset
REQ-027 SHALL, on rst=0, immediately force state IDLE, round=0, step_init=0, busy=0, done=0, err=0 and clear the watchdog count, including mid-permutation.
REQ-028 SHALL keep all outputs at reset values until the first rising clk edge after rst returns to 1.

Structure
REQ-029 SHALL take the state encoding, the step-bit index constants (THETA=0..IOTA=4) and the NROUNDS default from the shared package keccak_pkg.
REQ-030 SHALL place the per-step timeout counter in sub-module step_watchdog (inputs clear, enable; output expired at STEP_TO).

Verification
REQ-031 SHALL cover a nominal run: start, each engine answers step_done 2 cycles after its init -> 120 step_init pulses in order theta,rho,pi,chi,iota, round 0..23, done pulse once, busy low next cycle.
REQ-032 SHALL cover same-cycle done: step_done tied equal to step_init -> done asserts 121 cycles after start.
REQ-033 SHALL cover a stray completion: step_done[3] pulsed during THETA -> no state change, no missing or extra init.
REQ-034 SHALL cover timeout: STEP_TO=16, rho never answers -> err=1 at the 16th RHO cycle, state ERR, no done; abort -> IDLE; next start clears err.
REQ-035 SHALL cover abort and reset: abort in round 7 CHI -> IDLE next cycle, no done; rst=0 in round 12 PI -> all outputs 0 asynchronously, round=0.
REQ-036 SHALL cover start while busy: start pulsed in round 3 -> ignored, exactly one done at end.
